// File: rtl/receive2fifo_pkg.sv
// Shared constants for the UART receive-to-FIFO path.
//   BYTE_W    : width of a received byte
//   DEPTH_DEF : default holding-queue depth
//   CNT_W_DEF : default drop-counter width
//   clog2()   : ceiling log2, used to size the queue pointers and level
package receive2fifo_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned DEPTH_DEF = 2;
  localparam int unsigned CNT_W_DEF = 8;

  // Ceiling log2; returns at least 1 so one-bit pointers still exist.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/receive2fifo_rx_hold_queue.sv
// rx_hold_queue: generic circular queue with push, pop, full, empty and level.
//   clk, rst : clock, synchronous active-high reset (pointers/level only)
//   push     : store din at the write pointer (caller guarantees space)
//   pop      : discard the head entry (caller guarantees non-empty)
//   din      : data to store
//   dout     : head entry, valid whenever empty=0
//   full     : level == DEPTH
//   empty    : level == 0
//   level    : current occupancy
module rx_hold_queue
  import receive2fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned W     = BYTE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [W-1:0]          din,
  output logic [W-1:0]          dout,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] level
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Advance a pointer, wrapping modulo DEPTH.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Storage is never cleared; a push on a reset edge is discarded.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/receive2fifo.sv
// receive2fifo: moves UART receive bytes into the receive FIFO through a small
// holding queue; bytes arriving when the queue cannot take them are dropped
// and reported through a sticky overflow flag and saturating drop counter.
//   clk, rst       : clock, synchronous active-high reset
//   RxD_data_ready : one-cycle pulse, RxD_data valid
//   RxD_data       : received byte
//   buf_full       : receive FIFO full
//   wr_en          : FIFO write strobe (from registers and buf_full only)
//   buf_in         : byte presented to the FIFO (head of holding queue)
//   clr_overflow   : clears overflow and drop_count (a same-edge drop wins)
//   overflow       : sticky drop indicator
//   drop_count     : dropped-byte count, saturating at all-ones
//   hold_level     : holding-queue occupancy
module receive2fifo
  import receive2fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RxD_data_ready,
  input  logic [BYTE_W-1:0]     RxD_data,
  input  logic                  buf_full,
  output logic                  wr_en,
  output logic [BYTE_W-1:0]     buf_in,
  input  logic                  clr_overflow,
  output logic                  overflow,
  output logic [CNT_W-1:0]      drop_count,
  output logic [clog2(DEPTH):0] hold_level
);

  logic q_full;
  logic q_empty;
  logic push;
  logic drop;

  // Pop whenever the queue holds data and the FIFO can take it.
  assign wr_en = !q_empty && !buf_full;

  // A full queue that pops on this edge still has room for the incoming byte.
  assign push = RxD_data_ready && (!q_full || wr_en);
  assign drop = RxD_data_ready && q_full && !wr_en;

  rx_hold_queue #(
    .DEPTH (DEPTH),
    .W     (BYTE_W)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (wr_en),
    .din   (RxD_data),
    .dout  (buf_in),
    .full  (q_full),
    .empty (q_empty),
    .level (hold_level)
  );

  // Drop bookkeeping; a drop on a clear edge restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_overflow) begin
        drop_count <= CNT_W'(1);
      end else if (drop_count != '1) begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end else if (clr_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_receive2fifo.sv
// Self-checking bench for receive2fifo: directed scenarios plus a randomized
// run, all compared against a queue-based behavioural model.
module tb_receive2fifo;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 8;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic [7:0] data;
  logic       buf_full;
  logic       clr;
  logic       wr_en;
  logic [7:0] buf_in;
  logic       overflow;
  logic [CNT_W-1:0] drop_count;
  logic [1:0] hold_level;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [7:0] mq[$];
  bit         m_ovf;
  int         m_cnt;

  receive2fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .RxD_data_ready (rdy),
    .RxD_data       (data),
    .buf_full       (buf_full),
    .wr_en          (wr_en),
    .buf_in         (buf_in),
    .clr_overflow   (clr),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .hold_level     (hold_level)
  );

  always #5 clk = ~clk;

  task automatic setin(input bit r, input logic [7:0] d, input bit bf, input bit c, input bit rs);
    rdy = r; data = d; buf_full = bf; clr = c; rst = rs;
    #1;
  endtask

  // Advance the model by one edge using the current inputs, then clock the DUT.
  task automatic tick();
    bit pop;
    bit dropped;
    int occ;
    if (rst) begin
      mq.delete();
      m_ovf = 0;
      m_cnt = 0;
    end else begin
      pop = (mq.size() != 0) && !buf_full;
      occ = mq.size() - (pop ? 1 : 0);
      if (pop) void'(mq.pop_front());
      dropped = rdy && (occ >= DEPTH);
      if (rdy && !dropped) mq.push_back(data);
      if (dropped) begin
        m_ovf = 1;
        m_cnt = clr ? 1 : ((m_cnt == CMAX) ? CMAX : m_cnt + 1);
      end else if (clr) begin
        m_ovf = 0;
        m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    setin(0, 8'h00, 0, 0, 1);
    tick();
    setin(0, 8'h00, 0, 0, 0);
    total++;
    if (wr_en !== 1'b0 || hold_level !== 2'd0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
      bad++;
      $display("FAIL reset: wr_en=%b level=%0d ovf=%b cnt=%0d required 0/0/0/0",
               wr_en, hold_level, overflow, drop_count);
    end
  endtask

  task automatic test_single();
    setin(1, 8'hA5, 0, 0, 0);
    total++;
    if (wr_en !== 1'b0) begin
      bad++; $display("FAIL single_no_comb_path: wr_en=%b required 0", wr_en);
    end
    tick();
    setin(0, 8'h00, 0, 0, 0);
    total++;
    if (wr_en !== 1'b1 || buf_in !== 8'hA5 || hold_level !== 2'd1) begin
      bad++;
      $display("FAIL single_write: wr_en=%b buf_in=%h level=%0d required 1/a5/1", wr_en, buf_in, hold_level);
    end
    tick();
    total++;
    if (wr_en !== 1'b0 || hold_level !== 2'd0) begin
      bad++; $display("FAIL single_once: wr_en=%b level=%0d required 0/0", wr_en, hold_level);
    end
  endtask

  task automatic test_stall();
    setin(1, 8'h11, 1, 0, 0); tick();
    setin(1, 8'h22, 1, 0, 0); tick();
    setin(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (wr_en !== 1'b0 || hold_level !== 2'd2) begin
        bad++; $display("FAIL stall_hold: wr_en=%b level=%0d required 0/2", wr_en, hold_level);
      end
      tick();
    end
    setin(0, 8'h00, 0, 0, 0);
    total++;
    if (wr_en !== 1'b1 || buf_in !== 8'h11) begin
      bad++; $display("FAIL stall_first: wr_en=%b buf_in=%h required 1/11", wr_en, buf_in);
    end
    tick();
    total++;
    if (wr_en !== 1'b1 || buf_in !== 8'h22) begin
      bad++; $display("FAIL stall_second: wr_en=%b buf_in=%h required 1/22", wr_en, buf_in);
    end
    tick();
    total++;
    if (wr_en !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL stall_end: wr_en=%b ovf=%b required 0/0", wr_en, overflow);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) begin
      setin(1, 8'(i), 1, 0, 0);
      tick();
    end
    setin(0, 8'h00, 1, 0, 0);
    total++;
    if (overflow !== 1'b1 || drop_count !== 8'd2 || hold_level !== 2'd2) begin
      bad++;
      $display("FAIL overflow_flags: ovf=%b cnt=%0d level=%0d required 1/2/2", overflow, drop_count, hold_level);
    end
    setin(0, 8'h00, 0, 0, 0);
    total++;
    if (wr_en !== 1'b1 || buf_in !== 8'h01) begin
      bad++; $display("FAIL overflow_first: wr_en=%b buf_in=%h required 1/01", wr_en, buf_in);
    end
    tick();
    total++;
    if (wr_en !== 1'b1 || buf_in !== 8'h02) begin
      bad++; $display("FAIL overflow_second: wr_en=%b buf_in=%h required 1/02", wr_en, buf_in);
    end
    tick();
    total++;
    if (wr_en !== 1'b0) begin
      bad++; $display("FAIL overflow_no_more: wr_en=%b required 0", wr_en);
    end
    setin(0, 8'h00, 0, 1, 0); tick();
    setin(0, 8'h00, 0, 0, 0);
    total++;
    if (overflow !== 1'b0 || drop_count !== 8'd0) begin
      bad++; $display("FAIL overflow_clear: ovf=%b cnt=%0d required 0/0", overflow, drop_count);
    end
  endtask

  task automatic test_pop_push_full();
    setin(1, 8'h41, 1, 0, 0); tick();
    setin(1, 8'h42, 1, 0, 0); tick();
    setin(1, 8'h33, 0, 0, 0);
    total++;
    if (wr_en !== 1'b1 || buf_in !== 8'h41) begin
      bad++; $display("FAIL ppf_first: wr_en=%b buf_in=%h required 1/41", wr_en, buf_in);
    end
    tick();
    setin(0, 8'h00, 0, 0, 0);
    total++;
    if (overflow !== 1'b0 || hold_level !== 2'd2 || buf_in !== 8'h42) begin
      bad++;
      $display("FAIL ppf_no_drop: ovf=%b level=%0d buf_in=%h required 0/2/42", overflow, hold_level, buf_in);
    end
    tick();
    total++;
    if (wr_en !== 1'b1 || buf_in !== 8'h33) begin
      bad++; $display("FAIL ppf_third: wr_en=%b buf_in=%h required 1/33", wr_en, buf_in);
    end
    tick();
    total++;
    if (wr_en !== 1'b0 || hold_level !== 2'd0) begin
      bad++; $display("FAIL ppf_drained: wr_en=%b level=%0d required 0/0", wr_en, hold_level);
    end
  endtask

  task automatic test_clr_collision();
    for (int i = 0; i < 7; i++) begin
      setin(1, 8'(8'h50 + i), 1, 0, 0);
      tick();
    end
    setin(0, 8'h00, 1, 0, 0);
    total++;
    if (drop_count !== 8'd5) begin
      bad++; $display("FAIL collision_setup: cnt=%0d required 5", drop_count);
    end
    setin(1, 8'h99, 1, 1, 0); tick();
    setin(0, 8'h00, 1, 0, 0);
    total++;
    if (overflow !== 1'b1 || drop_count !== 8'd1) begin
      bad++; $display("FAIL collision: ovf=%b cnt=%0d required 1/1", overflow, drop_count);
    end
    // Saturation: push the counter well past all-ones.
    for (int i = 0; i < CMAX + 10; i++) begin
      setin(1, 8'hEE, 1, 0, 0);
      tick();
    end
    setin(0, 8'h00, 1, 0, 0);
    total++;
    if (drop_count !== 8'hFF || overflow !== 1'b1) begin
      bad++; $display("FAIL saturate: cnt=%0d ovf=%b required 255/1", drop_count, overflow);
    end
  endtask

  task automatic test_reset_mid();
    setin(0, 8'h00, 1, 0, 0);
    total++;
    if (hold_level !== 2'd2) begin
      bad++; $display("FAIL rstmid_setup: level=%0d required 2", hold_level);
    end
    setin(1, 8'h77, 0, 0, 1); tick();
    setin(0, 8'h00, 0, 0, 0);
    total++;
    if (wr_en !== 1'b0 || hold_level !== 2'd0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
      bad++;
      $display("FAIL rstmid: wr_en=%b level=%0d ovf=%b cnt=%0d required 0/0/0/0",
               wr_en, hold_level, overflow, drop_count);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (wr_en !== 1'b0) begin
        bad++; $display("FAIL rstmid_no_write: wr_en=%b buf_in=%h required wr_en 0", wr_en, buf_in);
      end
    end
  endtask

  task automatic test_random();
    bit exp_wr;
    for (int i = 0; i < 3000; i++) begin
      setin(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 50),
            ($urandom_range(0, 99) < 3), ($urandom_range(0, 199) == 0));
      exp_wr = (mq.size() != 0) && !buf_full;
      total++;
      if (wr_en !== exp_wr || hold_level !== 2'(mq.size()) || overflow !== m_ovf ||
          drop_count !== 8'(m_cnt) || (exp_wr && buf_in !== mq[0])) begin
        bad++;
        $display("FAIL random[%0d]: wr_en=%b level=%0d ovf=%b cnt=%0d buf_in=%h required %b/%0d/%b/%0d/%h",
                 i, wr_en, hold_level, overflow, drop_count, buf_in,
                 exp_wr, mq.size(), m_ovf, m_cnt, (mq.size() != 0) ? mq[0] : 8'h00);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; data = 8'h00; buf_full = 1'b0; clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_stall();
    test_overflow();
    test_pop_push_full();
    test_clr_collision();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/receive2fifo.md
Name: receive2fifo

Overview:
- Receive-side companion to the FIFO-to-UART transmit path.
- Accepts bytes from the UART receiver, one valid pulse per byte, and writes them into the receive FIFO. The game logic drains that FIFO.
- A small internal holding queue absorbs cycles in which the FIFO is full.
- Bytes that cannot be stored are dropped. Drops are reported through a sticky overflow flag and a saturating drop counter.

Parameters:
- DEPTH, 2, holding-queue entries. Power of two, range 2..8.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- RxD_data_ready  input  1  one-cycle pulse: RxD_data is valid this cycle.
- RxD_data  input  8  received byte.
- buf_full  input  1  receive FIFO full.
- wr_en  output  1  FIFO write strobe. The FIFO samples buf_in on the clk edge where wr_en=1.
- buf_in  output  8  byte presented to the FIFO.
- clr_overflow  input  1  clears overflow and drop_count.
- overflow  output  1  sticky: set once at least one byte has been dropped.
- drop_count  output  CNT_W  number of dropped bytes, saturating at all-ones.
- hold_level  output  log2(DEPTH)+1  current holding-queue occupancy.

Behaviour:
- Reset (rst=1 at a clk edge):
  - queue pointers and occupancy go to 0; hold_level=0, so wr_en=0.
  - overflow=0, drop_count=0.
  - queue contents are not cleared.
  - rst overrides every other input on the same edge.
  - A byte pulsed while rst=1 is discarded and not counted.
- Holding queue:
  - circular buffer with rd_ptr, wr_ptr and occupancy count.
  - pointers wrap modulo DEPTH.
- Write side (to FIFO):
  - wr_en = (occupancy != 0) && !buf_full. Combinational from registers and buf_full.
  - buf_in = queue[rd_ptr] at all times; it is don't-care when wr_en=0.
  - On an edge with wr_en=1: rd_ptr advances (pop).
- Receive side (push):
  - On an edge with RxD_data_ready=1: if the queue has space after this cycle's pop, store RxD_data at wr_ptr and advance wr_ptr.
  - "Space" means occupancy < DEPTH, or occupancy == DEPTH with a pop on the same edge.
  - So a full queue that pops in the same cycle still accepts the byte.
- Occupancy update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Latency: a byte pulsed in cycle t appears with wr_en=1 no earlier than cycle t+1, provided the queue was empty and buf_full=0.
- Ordering: bytes reach the FIFO in strict arrival order. No duplication, no reordering.
- Drop:
  - Condition: RxD_data_ready=1, occupancy==DEPTH, and no pop on that edge.
  - The incoming byte is discarded and the queue is unchanged.
  - overflow is set to 1.
  - drop_count increments; it holds at all-ones when saturated.
- clr_overflow:
  - On an edge with clr_overflow=1, overflow goes to 0 and drop_count goes to 0.
  - If a drop occurs on the same edge, the drop wins: overflow=1 and drop_count=1.
- A back-to-back RxD_data_ready=1 on consecutive cycles is legal and is treated as separate bytes.
- No combinational path from RxD_data_ready to wr_en.

Decomposition:
- Shared package holds:
  - the byte width constant (8);
  - DEPTH and CNT_W defaults;
  - the clog2 helper used for the pointer/level widths.
- One natural sub-module: rx_hold_queue, the generic circular queue with push, pop, full, empty and level.
- The top level adds the push/pop qualification and the overflow/drop_count bookkeeping.

Test Plan:
- Single byte:
  - stimulus: reset, then one RxD_data_ready pulse with RxD_data=8'hA5, buf_full=0.
  - required: next cycle wr_en=1 and buf_in=8'hA5 for exactly one cycle; hold_level returns to 0.
- FIFO-full stall:
  - stimulus: buf_full=1; pulse 8'h11 then 8'h22; release buf_full after 5 cycles.
  - required: wr_en=0 while buf_full=1 and hold_level=2. After release, wr_en=1 for two consecutive cycles carrying 8'h11 then 8'h22. overflow=0.
- Overflow:
  - stimulus: buf_full=1; pulse 8'h01, 8'h02, 8'h03, 8'h04 (DEPTH=2).
  - required: overflow=1, drop_count=2. After release only 8'h01 and 8'h02 are written.
- Pop/push same edge at full:
  - stimulus: queue full and buf_full drops in the same cycle that RxD_data_ready pulses 8'h33.
  - required: no drop; 8'h33 is written third.
- Clear vs drop collision:
  - stimulus: drop_count=5; clr_overflow=1 asserted on the same edge as a drop.
  - required: overflow=1, drop_count=1.
- Reset mid-operation:
  - stimulus: with hold_level=2, assert rst for 1 cycle while pulsing a byte.
  - required: wr_en=0, hold_level=0, overflow=0 and drop_count=0 the next cycle; the byte pulsed during rst is never written.
